// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : timer_sequencer
//  Description : Upstream controller for the 16-bit Timer stage. Holds a
//                table of interval lengths and walks the Timer through them
//                in order, waiting for the Timer end flag after each one.
//                Zero-length entries are skipped. The table can be replayed
//                continuously. Reports progress and pulses done on finish.
//  Ports       : clk, rst          - clock, async active-high reset
//                wr_en_i/wr_addr_i/wr_data_i - table write port
//                len_i, repeat_i   - sequence length / replay, taken on run_i
//                run_i, abort_i    - start pulse / stop request
//                end_i             - Timer end flag
//                n_o, start_o      - Timer interval length and enable
//                busy_o, idx_o     - activity flag, current table index
//                iter_cnt_o        - completed intervals since last run_i
//                done_o            - one-cycle finish/abort pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_sequencer #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [15:0]       wr_data_i,
   input  logic [ADDR_W:0]   len_i,
   input  logic              repeat_i,
   input  logic              run_i,
   input  logic              abort_i,
   input  logic              end_i,
   output logic [15:0]       n_o,
   output logic              start_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] idx_o,
   output logic [15:0]       iter_cnt_o,
   output logic              done_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_COUNT = 3'd2,
      S_ADV   = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] c_LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            r_state;
   logic [15:0]       r_tbl [DEPTH];
   logic [ADDR_W:0]   r_len;
   logic              r_rpt;
   logic              r_skip;      // current entry was zero and not counted
   logic              r_counted;   // at least one entry counted this pass
   logic [ADDR_W-1:0] r_idx;
   logic [15:0]       r_iter;
   logic [15:0]       r_n;
   logic              r_start;
   logic              r_done;

   logic [15:0]       w_entry;
   logic              w_last;
   logic [15:0]       w_iter_inc;

   assign w_entry    = r_tbl[r_idx];
   assign w_last     = ({1'b0, r_idx} == (r_len - c_LEN_ONE));
   assign w_iter_inc = (r_iter == 16'hFFFF) ? r_iter : r_iter + 16'd1;

   // Table storage is deliberately not reset so its contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         r_tbl[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_len     <= '0;
         r_rpt     <= 1'b0;
         r_skip    <= 1'b0;
         r_counted <= 1'b0;
         r_idx     <= '0;
         r_iter    <= '0;
         r_n       <= '0;
         r_start   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (run_i) begin
                  r_iter <= '0;
                  if (len_i != '0) begin
                     r_len     <= len_i;
                     r_rpt     <= repeat_i;
                     r_idx     <= '0;
                     r_counted <= 1'b0;
                     r_state   <= S_LOAD;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end
               end
            end

            S_LOAD: begin
               if (abort_i) begin
                  r_start <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  // n_o is captured here so later writes to this entry
                  // cannot disturb an interval already in progress.
                  r_n <= w_entry;
                  if (w_entry == 16'd0) begin
                     r_skip  <= 1'b1;
                     r_state <= S_ADV;
                  end else begin
                     r_skip  <= 1'b0;
                     r_start <= 1'b1;
                     r_state <= S_COUNT;
                  end
               end
            end

            S_COUNT: begin
               if (abort_i) begin
                  r_start <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else if (end_i) begin
                  r_start <= 1'b0;
                  r_state <= S_ADV;
               end
            end

            S_ADV: begin
               if (!r_skip) begin
                  r_iter    <= w_iter_inc;
                  r_counted <= 1'b1;
               end
               if (abort_i) begin
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else if (!w_last) begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_LOAD;
               end else if (r_rpt && (r_counted || !r_skip)) begin
                  // Wrap only if this pass counted something; an all-zero
                  // table would otherwise spin in LOAD/ADV forever.
                  r_idx     <= '0;
                  r_counted <= 1'b0;
                  r_state   <= S_LOAD;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end
            end

            S_FIN: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_start <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign n_o        = r_n;
   assign start_o    = r_start;
   assign busy_o     = (r_state != S_IDLE);
   assign idx_o      = r_idx;
   assign iter_cnt_o = r_iter;
   assign done_o     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_sequencer
//  Description : Self-checking bench for timer_sequencer. A behavioural
//                Timer drives end_i; a reference model predicts the list of
//                intervals and the final completed count for each run, and a
//                monitor compares them as start_o rises and done_o pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_sequencer;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_en_i = 1'b0;
   logic [ADDR_W-1:0] wr_addr_i = '0;
   logic [15:0]       wr_data_i = '0;
   logic [ADDR_W:0]   len_i = '0;
   logic              repeat_i = 1'b0;
   logic              run_i = 1'b0;
   logic              abort_i = 1'b0;
   logic              end_i;
   logic [15:0]       n_o;
   logic              start_o;
   logic              busy_o;
   logic [ADDR_W-1:0] idx_o;
   logic [15:0]       iter_cnt_o;
   logic              done_o;

   timer_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .len_i      (len_i),
      .repeat_i   (repeat_i),
      .run_i      (run_i),
      .abort_i    (abort_i),
      .end_i      (end_i),
      .n_o        (n_o),
      .start_o    (start_o),
      .busy_o     (busy_o),
      .idx_o      (idx_o),
      .iter_cnt_o (iter_cnt_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   // Behavioural Timer: count held at 0 while start is low, counts while
   // start is high, end flagged once the count reaches n.
   logic [15:0] t_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst)                t_cnt <= '0;
      else if (!start_o)      t_cnt <= '0;
      else if (t_cnt != n_o)  t_cnt <= t_cnt + 16'd1;
   end
   assign end_i = start_o && (t_cnt == n_o);

   typedef struct {
      int idx;
      int n;
   } ent_t;

   ent_t exp_q[$];
   int   exp_done_q[$];
   int   tbl_m [DEPTH];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT starts an interval or
   // signals completion.
   initial begin
      logic prev_start;
      logic prev_done;
      ent_t e;
      int   d;
      prev_start = 1'b0;
      prev_done  = 1'b0;
      forever begin
         @(negedge clk);
         if (start_o && !prev_start) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_start", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("start_n", 32'(n_o), 32'(e.n));
               chk("start_idx", 32'(idx_o), 32'(e.idx));
            end
         end
         if (done_o) begin
            if (exp_done_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               d = exp_done_q.pop_front();
               chk("done_iter_cnt", 32'(iter_cnt_o), 32'(d));
               chk("done_start_low", 32'(start_o), 32'd0);
            end
         end
         if (prev_done) chk("busy_after_done", 32'(busy_o), 32'd0);
         prev_start = start_o;
         prev_done  = done_o;
      end
   end

   task automatic wr(input int a, input int d);
      wr_en_i   = 1'b1;
      wr_addr_i = ADDR_W'(a);
      wr_data_i = 16'(d);
      tbl_m[a]  = d;
      @(negedge clk);
      wr_en_i   = 1'b0;
   endtask

   // Reference model: intervals actually counted are the non-zero entries
   // among the first len, in order, cycling if repeat is set. With repeat
   // and any non-zero entry, the run is aborted on the end of interval
   // number abort_after+1, which is therefore not counted.
   task automatic run_seq(input int len, input bit rpt, input int abort_after);
      int nz[$];
      int total;
      int ends;
      bit got;
      for (int i = 0; i < len; i++) if (tbl_m[i] != 0) nz.push_back(i);
      if (nz.size() == 0)  total = 0;
      else if (!rpt)       total = nz.size();
      else                 total = abort_after + 1;
      for (int k = 0; k < total; k++) exp_q.push_back('{nz[k % nz.size()], tbl_m[nz[k % nz.size()]]});
      exp_done_q.push_back((rpt && nz.size() > 0) ? abort_after : total);

      len_i = (ADDR_W + 1)'(len);
      repeat_i = rpt;
      run_i = 1'b1;
      @(negedge clk);
      run_i = 1'b0;
      got = done_o;
      if (len == 0) chk("len0_done_next_cycle", 32'(done_o), 32'd1);
      if (len > 0 && tbl_m[0] != 0) begin
         chk("latency_load_start_low", 32'(start_o), 32'd0);
         @(negedge clk);
         chk("latency_start_high", 32'(start_o), 32'd1);
      end
      ends = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         if (abort_i) begin
            abort_i = 1'b0;
            chk("abort_fin_next_cycle", 32'(done_o), 32'd1);
         end
         if (done_o) got = 1'b1;
         else if (rpt && start_o && end_i) begin
            ends++;
            if (ends == abort_after + 1) abort_i = 1'b1;
         end
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
      abort_i = 1'b0;
      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size() + exp_done_q.size()), 32'd0);
      exp_q.delete();
      exp_done_q.delete();
   endtask

   initial begin
      int len;
      bit rpt;
      for (int i = 0; i < DEPTH; i++) tbl_m[i] = 0;

      // Reset state
      @(negedge clk);
      chk("rst_n", 32'(n_o), 32'd0);
      chk("rst_start", 32'(start_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_idx", 32'(idx_o), 32'd0);
      chk("rst_iter", 32'(iter_cnt_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      rst = 1'b0;

      // Idle for 20 cycles: nothing moves
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("idle_quiet", {n_o, 13'd0, start_o, busy_o, done_o}, 32'd0);
      end

      // Two-entry sequence {5,3}
      wr(0, 5); wr(1, 3);
      run_seq(2, 1'b0, 0);

      // {4,0,2}: middle entry skipped
      wr(0, 4); wr(1, 0); wr(2, 2);
      run_seq(3, 1'b0, 0);

      // {2,2} repeating, abort together with the 6th end
      wr(0, 2); wr(1, 2);
      run_seq(2, 1'b1, 5);

      // Zero length run
      run_seq(0, 1'b0, 0);

      // All-zero table with repeat terminates after one pass
      wr(0, 0); wr(1, 0);
      run_seq(2, 1'b1, 0);

      // Asynchronous reset mid-COUNT; table survives
      wr(0, 7);
      exp_q.push_back('{0, 7});
      len_i = 1; repeat_i = 1'b0; run_i = 1'b1;
      @(negedge clk);
      run_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_counting", 32'(start_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_n", 32'(n_o), 32'd0);
      chk("async_rst_start", 32'(start_o), 32'd0);
      chk("async_rst_busy", 32'(busy_o), 32'd0);
      chk("async_rst_idx", 32'(idx_o), 32'd0);
      chk("async_rst_iter", 32'(iter_cnt_o), 32'd0);
      chk("async_rst_done", 32'(done_o), 32'd0);
      exp_q.delete();
      exp_done_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_seq(1, 1'b0, 0);

      // Randomized runs
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < DEPTH; i++)
            wr(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)));
         len = int'($urandom_range(0, DEPTH));
         rpt = ($urandom_range(0, 2) == 0);
         run_seq(len, rpt, int'($urandom_range(0, 6)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
